// File: rtl/logreg_class_scheduler.sv
// Sequences one shared inner-product datapath over every one-vs-all theta set
// for a held 9x9 window and returns the argmax class and its score.
module logreg_class_scheduler #(
  parameter int NUM_CLASSES = 10,
  parameter int NPIX        = 81,
  parameter int PIX_W       = 7,
  parameter int ACC_W       = 32,
  parameter int CLS_W       = 4,
  parameter int IP_LAT      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  win_valid,
  output logic                  win_ready,
  input  logic [NPIX*PIX_W-1:0] win_data,
  output logic [NPIX*PIX_W-1:0] x_hold,
  output logic [CLS_W-1:0]      class_sel,
  input  logic [ACC_W-1:0]      hprime,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CLS_W-1:0]      res_class,
  output logic [ACC_W-1:0]      res_score,
  output logic [1:0]            state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds with stable data until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_e;

  localparam logic [CLS_W-1:0] LAST = CLS_W'(NUM_CLASSES - 1);

  state_e                  state_q, state_d;
  logic                    init_q;
  logic [NPIX*PIX_W-1:0]   x_hold_q, x_hold_d;
  logic [CLS_W-1:0]        issue_cnt_q, issue_cnt_d;
  logic                    issue_done_q, issue_done_d;
  logic [CLS_W-1:0]        cap_cnt_q, cap_cnt_d;
  logic signed [ACC_W-1:0] best_q, best_d;
  logic [CLS_W-1:0]        best_cls_q, best_cls_d;
  logic [CLS_W-1:0]        res_class_q, res_class_d;
  logic [ACC_W-1:0]        res_score_q, res_score_d;
  logic                    issue_vld;
  logic                    cap_vld;

  assign issue_vld = (state_q == EVAL) && !issue_done_q;

  // Issue-valid delay line: a capture lines up with the hprime of the class
  // that was issued IP_LAT cycles earlier.
  generate
    if (IP_LAT == 0) begin : g_nolat
      assign cap_vld = issue_vld;
    end else begin : g_lat
      logic [IP_LAT-1:0] pipe_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= issue_vld;
          for (int i = 1; i < IP_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign cap_vld = pipe_q[IP_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      init_q       <= 1'b0;
      x_hold_q     <= '0;
      issue_cnt_q  <= '0;
      issue_done_q <= 1'b0;
      cap_cnt_q    <= '0;
      best_q       <= '0;
      best_cls_q   <= '0;
      res_class_q  <= '0;
      res_score_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_q       <= 1'b1;
      x_hold_q     <= x_hold_d;
      issue_cnt_q  <= issue_cnt_d;
      issue_done_q <= issue_done_d;
      cap_cnt_q    <= cap_cnt_d;
      best_q       <= best_d;
      best_cls_q   <= best_cls_d;
      res_class_q  <= res_class_d;
      res_score_q  <= res_score_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    x_hold_d     = x_hold_q;
    issue_cnt_d  = issue_cnt_q;
    issue_done_d = issue_done_q;
    cap_cnt_d    = cap_cnt_q;
    best_d       = best_q;
    best_cls_d   = best_cls_q;
    res_class_d  = res_class_q;
    res_score_d  = res_score_q;
    case (state_q)
      IDLE: begin
        if (win_valid && win_ready) begin
          x_hold_d     = win_data;
          issue_cnt_d  = '0;
          issue_done_d = 1'b0;
          cap_cnt_d    = '0;
          state_d      = EVAL;
        end
      end
      EVAL: begin
        if (issue_vld) begin
          if (issue_cnt_q == LAST) issue_done_d = 1'b1;
          else                     issue_cnt_d  = issue_cnt_q + CLS_W'(1);
        end
        if (cap_vld) begin
          // Strict greater-than keeps the lower class index on ties.
          if (cap_cnt_q == '0 || $signed(hprime) > best_q) begin
            best_d     = $signed(hprime);
            best_cls_d = cap_cnt_q;
          end
          if (cap_cnt_q == LAST) begin
            res_class_d = best_cls_d;
            res_score_d = best_d;
            state_d     = DONE;
          end else begin
            cap_cnt_d = cap_cnt_q + CLS_W'(1);
          end
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign win_ready = init_q && (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign x_hold    = x_hold_q;
  assign class_sel = issue_cnt_q;
  assign res_class = res_class_q;
  assign res_score = res_score_q;
  assign state_dbg = state_q;

endmodule
